// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
//   Pipelined RISC-V immediate generator. Decodes the I, S, B, J and U
//   immediate formats, plus the CSR zimm format when built with the
//   IMM_GEN_CSR_ZIMM_EN macro. The decoded word and a sideband tag travel
//   through PIPE elastic stages. Each stage holds a main register and a skid
//   register and uses a valid/ready handshake.
//
//   Parameters
//     XLEN   immediate width (32 or 64), sign extended to the full width
//     TAG_W  sideband tag width
//     PIPE   number of elastic stages (1..4); latency is PIPE cycles
//
//   Ports
//     clk, reset          rising-edge clock, synchronous active-high reset
//     flush               one-cycle pulse that empties every stage
//     in_valid/in_ready   input handshake
//     in_instr            instruction bits [31:7]
//     in_immsrc           format select: 000 I, 001 S, 010 B, 011 J, 100 U,
//                         101 CSR zimm (macro only), anything else is illegal
//     in_tag              sideband tag, passed through unchanged
//     out_valid/out_ready output handshake
//     out_imm             extended immediate
//     out_tag             tag carried with out_imm
//     out_illegal         format select was unsupported; out_imm is zero
//     busy                at least one word is held in the pipe
//
//   Build option
//     IMM_GEN_CSR_ZIMM_EN  when defined, immsrc 101 yields the zero-extended
//                          zimm field instr[19:15]; otherwise it is illegal.

module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int PIPE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_instr,
  input  logic [2:0]       in_immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic             busy
);

  // Entry layout: {illegal, tag, imm}
  localparam int W = XLEN + TAG_W + 1;

  logic [31:7]        ins;
  logic signed [31:0] imm32;
  logic               dec_illegal;
  logic [XLEN-1:0]    dec_imm;

  logic [PIPE-1:0] main_valid_q, main_valid_d;
  logic [PIPE-1:0] skid_valid_q, skid_valid_d;
  logic [W-1:0]    main_data_q [PIPE];
  logic [W-1:0]    main_data_d [PIPE];
  logic [W-1:0]    skid_data_q [PIPE];
  logic [W-1:0]    skid_data_d [PIPE];

  logic [PIPE-1:0] accept;
  logic [PIPE-1:0] consume;

  // Position i of each chain is what stage i sees from upstream; position
  // i+1 of chain_ready is the ready of whatever sits downstream of stage i.
  logic [PIPE:0]   chain_valid;
  logic [PIPE:0]   chain_ready;
  logic [W-1:0]    chain_data [PIPE+1];

  assign ins = in_instr;

  // Every format fits in 32 bits before extension, so it is built as a
  // signed 32-bit value and then widened with a single signed cast. The
  // zimm value is positive, so sign extension leaves it zero-extended.
  always_comb begin
    imm32       = '0;
    dec_illegal = 1'b0;
    case (in_immsrc)
      3'b000:  imm32 = {{20{ins[31]}}, ins[31:20]};
      3'b001:  imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      3'b010:  imm32 = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      3'b011:  imm32 = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      3'b100:  imm32 = {ins[31:12], 12'b0};
`ifdef IMM_GEN_CSR_ZIMM_EN
      3'b101:  imm32 = {27'b0, ins[19:15]};
`endif
      default: dec_illegal = 1'b1;
    endcase
  end

  assign dec_imm = XLEN'(imm32);

  assign chain_valid = {main_valid_q, in_valid};
  assign chain_ready = {out_ready, ~skid_valid_q};

  // Stage 0 takes the freshly decoded word; later stages take the main
  // register of the stage in front of them.
  always_comb begin
    chain_data[0] = {dec_illegal, in_tag, dec_imm};
    for (int i = 0; i < PIPE; i++) begin
      chain_data[i+1] = main_data_q[i];
    end
  end

  // Per-stage elastic control. The main register is always the one shown
  // downstream. When it drains and the skid holds a word, the skid refills
  // main and the stage is not ready that cycle. A word arriving while main
  // is stalled parks in the skid, which then drops ready for the next cycle.
  // Flush clears only the valid flags; the data registers keep their values.
  always_comb begin
    for (int i = 0; i < PIPE; i++) begin
      accept[i]       = chain_valid[i] && !skid_valid_q[i];
      consume[i]      = main_valid_q[i] && chain_ready[i+1];
      main_valid_d[i] = main_valid_q[i];
      skid_valid_d[i] = skid_valid_q[i];
      main_data_d[i]  = main_data_q[i];
      skid_data_d[i]  = skid_data_q[i];
      if (flush) begin
        main_valid_d[i] = 1'b0;
        skid_valid_d[i] = 1'b0;
      end else if (consume[i] && skid_valid_q[i]) begin
        main_data_d[i]  = skid_data_q[i];
        skid_valid_d[i] = 1'b0;
      end else if (consume[i] || !main_valid_q[i]) begin
        main_valid_d[i] = accept[i];
        if (accept[i]) begin
          main_data_d[i] = chain_data[i];
        end
      end else if (accept[i]) begin
        skid_valid_d[i] = 1'b1;
        skid_data_d[i]  = chain_data[i];
      end
    end
  end

  // State registers; reset clears both flags and data so the outputs read
  // all zero straight after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= '0;
      skid_valid_q <= '0;
      for (int i = 0; i < PIPE; i++) begin
        main_data_q[i] <= '0;
        skid_data_q[i] <= '0;
      end
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      for (int i = 0; i < PIPE; i++) begin
        main_data_q[i] <= main_data_d[i];
        skid_data_q[i] <= skid_data_d[i];
      end
    end
  end

  // Ready is masked while reset is asserted so upstream never sees a
  // handshake that the reset is about to discard.
  assign in_ready = !skid_valid_q[0] && !reset;

  assign out_valid = main_valid_q[PIPE-1];
  assign {out_illegal, out_tag, out_imm} = main_data_q[PIPE-1];

  // A skid entry can only exist behind a valid main entry, but both are
  // included so busy never depends on that invariant.
  assign busy = |{main_valid_q, skid_valid_q};

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe
//   Bench for imm_gen_pipe. Two instances share the same inputs:
//   dut_a (XLEN=32, PIPE=1) and dut_b (XLEN=64, PIPE=2). Each has its own
//   handshake outputs and its own queue-based reference model. Constant
//   vectors come from a table, there are hand sequences for back-pressure,
//   flush and reset, and a long randomized run at the end.

module tb_imm_gen_pipe;

  localparam int TAG_W = 5;

  typedef struct {
    logic [2:0]  src;
    logic [31:0] instr;
    logic [63:0] exp32;
    logic [63:0] exp64;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [63:0]      imm;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             out_ready;
  logic [24:0]      in_instr;
  logic [2:0]       in_immsrc;
  logic [TAG_W-1:0] in_tag;

  logic             in_ready_a, out_valid_a, out_illegal_a, busy_a;
  logic [31:0]      out_imm_a;
  logic [TAG_W-1:0] out_tag_a;
  logic             in_ready_b, out_valid_b, out_illegal_b, busy_b;
  logic [63:0]      out_imm_b;
  logic [TAG_W-1:0] out_tag_b;

  int total;
  int bad;

  exp_t sb_a[$];
  exp_t sb_b[$];
  logic             stall_prev [2];
  logic [63:0]      imm_prev   [2];
  logic [TAG_W-1:0] tag_prev   [2];
  logic             ill_prev   [2];

  vec_t vecs [11];

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W), .PIPE(1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_imm(out_imm_a), .out_tag(out_tag_a),
    .out_illegal(out_illegal_a), .busy(busy_a)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W), .PIPE(2)) dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_imm(out_imm_b), .out_tag(out_tag_b),
    .out_illegal(out_illegal_b), .busy(busy_b)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode computed arithmetically from the signed instruction
  // word: shift the sign-carrying field into place, OR in the rest.
  function automatic exp_t refWord(input logic [31:0] ins, input logic [2:0] src,
                                   input logic [TAG_W-1:0] tag, input int xlen);
    exp_t   e;
    longint s;
    longint v;
    s = longint'($signed(ins));
    v = 0;
    e.ill = 1'b0;
    case (src)
      3'd0: v = s >>> 20;
      3'd1: v = ((s >>> 25) <<< 5) | longint'(ins[11:7]);
      3'd2: v = ((s >>> 31) <<< 12) | (longint'(ins[7]) << 11)
              | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
      3'd3: v = ((s >>> 31) <<< 20) | (longint'(ins[19:12]) << 12)
              | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
      3'd4: v = s & ~longint'(64'hFFF);
`ifdef IMM_GEN_CSR_ZIMM_EN
      3'd5: v = longint'(ins[19:15]);
`endif
      default: e.ill = 1'b1;
    endcase
    if (xlen == 32) v = v & longint'(64'h0000_0000_FFFF_FFFF);
    e.imm = v;
    e.tag = tag;
    return e;
  endfunction

  // One comparison: counts it and reports a mismatch
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one table vector onto the shared inputs for one handshake
  task automatic applyStimulus(input vec_t v, input int idx);
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_instr  = v.instr[31:7];
    in_immsrc = v.src;
    in_tag    = TAG_W'(idx);
  endtask

  // Scoreboard step for one instance, evaluated between edges: checks busy
  // against the model occupancy, output stability under stall, and the
  // delivered word against the queue head, then applies this edge's events.
  task automatic monitorStep(input int id, input int xlen, input int cap, input logic rdy,
                             input logic ov, input logic [63:0] oimm,
                             input logic [TAG_W-1:0] otag, input logic oill, input logic obusy);
    exp_t  e;
    int    depth;
    string nm;
    nm = (id == 0) ? "a" : "b";
    if (reset) begin
      if (id == 0) sb_a.delete(); else sb_b.delete();
      stall_prev[id] = 1'b0;
    end else begin
      depth = (id == 0) ? sb_a.size() : sb_b.size();
      checkOutput({"busy_", nm}, 64'(obusy), 64'(depth != 0));
      if (stall_prev[id]) begin
        checkOutput({"hold_valid_", nm}, 64'(ov), 64'd1);
        checkOutput({"hold_imm_", nm}, oimm, imm_prev[id]);
        checkOutput({"hold_tag_", nm}, 64'(otag), 64'(tag_prev[id]));
        checkOutput({"hold_ill_", nm}, 64'(oill), 64'(ill_prev[id]));
      end
      if (ov && out_ready) begin
        checkOutput({"out_expected_", nm}, 64'(depth != 0), 64'd1);
        if (depth != 0) begin
          e = (id == 0) ? sb_a.pop_front() : sb_b.pop_front();
          checkOutput({"imm_", nm}, oimm, e.imm);
          checkOutput({"tag_", nm}, 64'(otag), 64'(e.tag));
          checkOutput({"ill_", nm}, 64'(oill), 64'(e.ill));
        end
      end
      if (flush) begin
        if (id == 0) sb_a.delete(); else sb_b.delete();
      end else if (in_valid && rdy) begin
        e = refWord({in_instr, 7'b0}, in_immsrc, in_tag, xlen);
        if (id == 0) sb_a.push_back(e); else sb_b.push_back(e);
      end
      depth = (id == 0) ? sb_a.size() : sb_b.size();
      checkOutput({"capacity_", nm}, 64'(depth <= cap), 64'd1);
      stall_prev[id] = ov && !out_ready && !flush;
      imm_prev[id]   = oimm;
      tag_prev[id]   = otag;
      ill_prev[id]   = oill;
    end
  endtask

  // Inputs change just after posedge, so values seen at negedge are the
  // ones the next posedge will act on.
  always @(negedge clk) begin
    monitorStep(0, 32, 2, in_ready_a, out_valid_a, {32'b0, out_imm_a}, out_tag_a, out_illegal_a, busy_a);
    monitorStep(1, 64, 4, in_ready_b, out_valid_b, out_imm_b, out_tag_b, out_illegal_b, busy_b);
  end

  // Hard stop in case the sequence below ever stalls
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: sequence did not complete");
    $fatal(1, "[TB] timeout");
  end

  // Main sequence
  initial begin
    int nacc;
    int ready_pct;
    total = 0;
    bad   = 0;
    stall_prev[0] = 1'b0;
    stall_prev[1] = 1'b0;
    imm_prev[0] = '0; imm_prev[1] = '0;
    tag_prev[0] = '0; tag_prev[1] = '0;
    ill_prev[0] = 1'b0; ill_prev[1] = 1'b0;

    vecs[0]  = '{3'd0, 32'hFFF00093, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1]  = '{3'd1, 32'hFE20AE23, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[2]  = '{3'd3, 32'h0010006F, 64'h00000800, 64'h0000000000000800, 1'b0};
    vecs[3]  = '{3'd4, 32'h123452B7, 64'h12345000, 64'h0000000012345000, 1'b0};
    vecs[4]  = '{3'd4, 32'h800002B7, 64'h80000000, 64'hFFFFFFFF80000000, 1'b0};
    vecs[5]  = '{3'd2, 32'hFE000EE3, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[6]  = '{3'd0, 32'h7FF00013, 64'h000007FF, 64'h00000000000007FF, 1'b0};
    vecs[7]  = '{3'd7, 32'hFFFFFFFF, 64'h0,        64'h0,                1'b1};
    vecs[8]  = '{3'd6, 32'h12345678, 64'h0,        64'h0,                1'b1};
`ifdef IMM_GEN_CSR_ZIMM_EN
    vecs[9]  = '{3'd5, 32'hFFFFFFF3, 64'h0000001F, 64'h000000000000001F, 1'b0};
`else
    vecs[9]  = '{3'd5, 32'hFFFFFFF3, 64'h0,        64'h0,                1'b1};
`endif
    vecs[10] = '{3'd1, 32'h00112423, 64'h00000008, 64'h0000000000000008, 1'b0};

    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_instr  = '0;
    in_immsrc = '0;
    in_tag    = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready_a", 64'(in_ready_a), 64'd0);
    checkOutput("rst_in_ready_b", 64'(in_ready_b), 64'd0);
    checkOutput("rst_out_valid_b", 64'(out_valid_b), 64'd0);
    checkOutput("rst_out_imm_b", out_imm_b, 64'd0);
    checkOutput("rst_out_tag_b", 64'(out_tag_b), 64'd0);
    checkOutput("rst_out_ill_a", 64'(out_illegal_a), 64'd0);
    checkOutput("rst_busy_a", 64'(busy_a), 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("post_rst_in_ready_a", 64'(in_ready_a), 64'd1);
    checkOutput("post_rst_in_ready_b", 64'(in_ready_b), 64'd1);

    // Table vectors: dut_a shows the word one cycle after acceptance,
    // dut_b one cycle later still
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i], i);
      @(posedge clk); #1;
      in_valid = 1'b0;
      checkOutput($sformatf("vec%0d_valid_a", i), 64'(out_valid_a), 64'd1);
      checkOutput($sformatf("vec%0d_imm_a", i), {32'b0, out_imm_a}, vecs[i].exp32);
      checkOutput($sformatf("vec%0d_ill_a", i), 64'(out_illegal_a), 64'(vecs[i].ill));
      checkOutput($sformatf("vec%0d_tag_a", i), 64'(out_tag_a), 64'(i));
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d_valid_b", i), 64'(out_valid_b), 64'd1);
      checkOutput($sformatf("vec%0d_imm_b", i), out_imm_b, vecs[i].exp64);
      checkOutput($sformatf("vec%0d_ill_b", i), 64'(out_illegal_b), 64'(vecs[i].ill));
      checkOutput($sformatf("vec%0d_tag_b", i), 64'(out_tag_b), 64'(i));
    end

    // Back-to-back words at one per cycle, tags 0..3 in order on dut_a
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_immsrc = 3'd4;
    in_instr  = 25'h0123400;
    in_tag    = 5'd0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("b2b_valid_%0d", k), 64'(out_valid_a), 64'd1);
      checkOutput($sformatf("b2b_tag_%0d", k), 64'(out_tag_a), 64'(k));
      in_tag   = TAG_W'(k + 1);
      in_instr = in_instr + 25'h11111;
      if (k == 3) in_valid = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;

    // Back-pressure on dut_b: capacity is four words, then ready drops
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_immsrc = 3'd0;
    nacc      = 0;
    in_tag    = 5'd0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (in_ready_b) nacc++;
      @(posedge clk); #1;
      in_tag   = TAG_W'(nacc);
      in_instr = 25'(nacc * 25'h40000);
    end
    in_valid = 1'b0;
    checkOutput("bp_accepted", 64'(nacc), 64'd4);
    checkOutput("bp_in_ready", 64'(in_ready_b), 64'd0);
    checkOutput("bp_busy", 64'(busy_b), 64'd1);
    out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_drain_valid_%0d", t), 64'(out_valid_b), 64'd1);
      checkOutput($sformatf("bp_drain_tag_%0d", t), 64'(out_tag_b), 64'(t));
    end
    @(negedge clk);
    checkOutput("bp_drained_valid", 64'(out_valid_b), 64'd0);
    checkOutput("bp_drained_busy", 64'(busy_b), 64'd0);
    repeat (3) @(posedge clk);
    #1;

    // Flush with three words in flight and a word offered in the same cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_immsrc = 3'd1;
    for (int k = 0; k < 3; k++) begin
      in_tag = TAG_W'(10 + k);
      @(posedge clk); #1;
    end
    flush  = 1'b1;
    in_tag = 5'd13;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_valid_b", 64'(out_valid_b), 64'd0);
    checkOutput("flush_busy_b", 64'(busy_b), 64'd0);
    checkOutput("flush_valid_a", 64'(out_valid_a), 64'd0);
    checkOutput("flush_busy_a", 64'(busy_a), 64'd0);
    checkOutput("flush_keeps_data_b", 64'(out_tag_b), 64'd10);
    out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("flush_no_out_%0d", t), 64'(out_valid_b), 64'd0);
    end

    // Reset in mid-stream: nothing survives and data registers read zero
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_immsrc = 3'd7;
    in_tag    = 5'd21;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    checkOutput("mid_rst_in_ready_a", 64'(in_ready_a), 64'd0);
    @(posedge clk); #1;
    checkOutput("mid_rst_valid_b", 64'(out_valid_b), 64'd0);
    checkOutput("mid_rst_imm_b", out_imm_b, 64'd0);
    checkOutput("mid_rst_tag_b", 64'(out_tag_b), 64'd0);
    checkOutput("mid_rst_ill_b", 64'(out_illegal_b), 64'd0);
    checkOutput("mid_rst_busy_b", 64'(busy_b), 64'd0);
    checkOutput("mid_rst_valid_a", 64'(out_valid_a), 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_ready_b", 64'(in_ready_b), 64'd1);

    // Randomized traffic with alternating light and heavy back-pressure
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      ready_pct = (((c / 500) % 2) == 1) ? 30 : 85;
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < ready_pct);
      flush     = ($urandom_range(0, 199) == 0);
      in_instr  = 25'($urandom);
      in_immsrc = 3'($urandom_range(0, 7));
      in_tag    = TAG_W'($urandom);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    checkOutput("final_pending_a", 64'(sb_a.size()), 64'd0);
    checkOutput("final_pending_b", 64'(sb_b.size()), 64'd0);
    checkOutput("final_busy_b", 64'(busy_b), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
